c3_writeback_buffer: RTL and testbench
======================================

# c3_writeback_buffer

- Sits directly downstream of the C3 custom SIMD pipeline.
- The C3 pipeline has a fixed latency and cannot be stalled. This block captures every result it emits (`out_v`, `out_rd`, `out_vrd1/2`, `out_data`, `out_vdata1/2`) into a small FIFO.
- It presents queued results to the core's register-file write port with a valid/ready handshake.
- A credit counter grants issue permission so that results still in flight can never overflow the buffer. A flush mode discards results belonging to squashed instructions.

## Interface
Parameters:
- `DEPTH`, 8: result entries buffered; power of two, ≥ 2.
- `PIPE_CYCLES`, 5: C3 pipeline latency; upper bound on results in flight.
- `VLEN`, 128: vector data width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `issue_v`  in  1  core launches an instruction into C3 this cycle.
- `issue_ok`  out  1  credit available; core may assert `issue_v` only when high.
- `flush`  in  1  one-cycle pulse; squash all queued and in-flight results.
- `in_v`  in  1  C3 result valid.
- `in_rd`  in  5  scalar destination.
- `in_vrd1`, `in_vrd2`  in  3 each  vector destinations.
- `in_data`  in  32  scalar result.
- `in_vdata1`, `in_vdata2`  in  VLEN each  vector results.
- `wb_valid`  out  1  head entry available.
- `wb_ready`  in  1  register file accepts head.
- `wb_rd`, `wb_vrd1`, `wb_vrd2`, `wb_data`, `wb_vdata1`, `wb_vdata2`  out  widths as inputs  head entry fields.
- `wb_we_x`  out  1  scalar write enable: `wb_valid && wb_rd != 0`.
- `count`  out  $clog2(DEPTH)+1  entries queued.
- `overflow`  out  1  sticky error flag.

## Operation
- **Storage:** circular FIFO with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
- **Push:** occurs when `in_v` is high in mode NORMAL and the FIFO is not full, or when it is full and a pop happens in the same cycle.
- **Pop:** occurs when `wb_valid && wb_ready`.
- **Simultaneous push and pop:** occupancy is unchanged. This holds at full and at one entry.
- **Head data:** the `wb_*` outputs are driven from the head entry.
- **In-flight counter `inflight`** (range 0..PIPE_CYCLES):
  - +1 on `issue_v && issue_ok`.
  - −1 on `in_v`.
  - Both in the same cycle: unchanged.
  - `issue_v` while `issue_ok` is low is ignored and not counted.
- **Credit:** `issue_ok = (count + inflight) < DEPTH`. It is computed combinationally from registered state only.
- **Overflow:** `in_v` arriving when full with no pop drops the result and sets `overflow`. Only reset clears `overflow`.
- **State machine (mode):**
  - NORMAL → DISCARD on `flush` when `inflight` minus any `in_v` arriving that cycle is > 0. `discard_cnt` is loaded with that value.
  - NORMAL → NORMAL on `flush` when no results remain in flight.
  - In DISCARD, each `in_v` decrements both `discard_cnt` and `inflight` and is not stored.
  - DISCARD → NORMAL in the cycle `discard_cnt` reaches 0.
  - `issue_ok` is forced low while in DISCARD.
- **Flush:** clears the FIFO (both pointers and `count` to 0) in the same edge. Any pop or push in that cycle is void. A `flush` received while in DISCARD reloads `discard_cnt` from the current `inflight`.
- **No reordering:** results leave in arrival order.

## Timing
- **Reset values:**
  - `wb_valid` = 0, `count` = 0, `overflow` = 0.
  - All `wb_*` data outputs = 0; `wb_we_x` = 0.
  - `issue_ok` = 1; mode = NORMAL; `inflight` = 0, `discard_cnt` = 0; pointers = 0.
- **Reset mid-operation:** `reset_n` low at any point returns all state to the reset values immediately, without waiting for a clock edge.
- **Input-to-writeback latency:** 1 cycle. `in_v` sampled at edge N into an empty FIFO gives `wb_valid` high from edge N onward, i.e. visible in cycle N+1.
- **Throughput:** one push and one pop per cycle sustained.
- **Credit response:** a credit taken at edge N lowers `issue_ok` from cycle N+1 if the total reaches DEPTH. A pop at edge N frees a credit visible in cycle N+1.
- **Handshake:** `wb_*` outputs are held stable while `wb_valid && !wb_ready`.

## Structure
- **Shared package `c3_pkg`:**
  - `VLEN` and `C3_PIPE_CYCLES` constants, also used by the C3 pipeline.
  - Packed struct `c3_result_t` holding rd, vrd1, vrd2, data, vdata1, vdata2 (299 bits at VLEN = 128).
  - Mode enum: NORMAL, DISCARD.
- **Sub-module `c3_wb_fifo`:** storage array, pointers and `count`, with push/pop/clear ports.
- **Top level:** credit counter, flush FSM and overflow flag.

## Test plan
- **Single result:** reset, issue 1, drive `in_v` 5 cycles later with rd=3, data=0x2A, `wb_ready`=1. Expect `wb_valid` for exactly 1 cycle, `wb_rd`=3, `wb_data`=0x2A, `wb_we_x`=1, then `count`=0 and `inflight`=0.
- **Credit limit:** `wb_ready`=0, keep `issue_v` high. Expect exactly 8 issues accepted, `issue_ok` low from the 9th cycle, and `count` reaching 8 with `overflow`=0.
- **Full with concurrent pop:** FIFO full, `in_v` and `wb_ready` high together for 4 cycles. Expect `count` held at 8, FIFO order preserved, `overflow`=0.
- **Forced overflow:** drive `in_v` with `issue_v` tied low while full and `wb_ready`=0. Expect the entry dropped, `overflow`=1, and it stays 1 until `reset_n` is asserted.
- **Flush with results in flight:** 3 in flight, 2 queued; pulse `flush`. Expect `count`=0 next cycle, the next 3 `in_v` discarded, `issue_ok` low until the 3rd discard completes, then high.
- **Async reset:** assert `reset_n`=0 between clock edges while `wb_valid`=1. Expect `wb_valid` to fall immediately, and `count`=0, `issue_ok`=1 after release.

Source files
------------

// File: rtl/c3_pkg.sv
// Shared C3 definitions: datapath widths, pipeline latency, result record and
// writeback-buffer mode encoding.
package c3_pkg;

   localparam int VLEN           = 128;
   localparam int C3_PIPE_CYCLES = 5;

   typedef struct packed {
      logic [4:0]      rd;
      logic [2:0]      vrd1;
      logic [2:0]      vrd2;
      logic [31:0]     data;
      logic [VLEN-1:0] vdata1;
      logic [VLEN-1:0] vdata2;
   } c3_result_t;

   typedef enum logic [0:0] {
      NORMAL  = 1'b0,
      DISCARD = 1'b1
   } c3_mode_t;

endpackage

// File: rtl/c3_wb_fifo.sv
// Circular result FIFO with occupancy count; head data reads as zero when empty
// so the writeback port shows clean zeros out of reset.
module c3_wb_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign rdata = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/c3_writeback_buffer.sv
// Writeback buffer behind the non-stallable C3 pipeline: queues results, grants
// issue credits so in-flight results always fit, and drops squashed results.
//
//   state   | meaning
//   NORMAL  | results are queued; credits granted while count+inflight < DEPTH
//   DISCARD | squashed results still in flight; each arrival is dropped, no issue
module c3_writeback_buffer #(
   parameter int DEPTH       = 8,
   parameter int PIPE_CYCLES = c3_pkg::C3_PIPE_CYCLES,
   parameter int VLEN        = c3_pkg::VLEN
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   issue_v,
   output logic                   issue_ok,
   input  logic                   flush,
   input  logic                   in_v,
   input  logic [4:0]             in_rd,
   input  logic [2:0]             in_vrd1,
   input  logic [2:0]             in_vrd2,
   input  logic [31:0]            in_data,
   input  logic [VLEN-1:0]        in_vdata1,
   input  logic [VLEN-1:0]        in_vdata2,
   output logic                   wb_valid,
   input  logic                   wb_ready,
   output logic [4:0]             wb_rd,
   output logic [2:0]             wb_vrd1,
   output logic [2:0]             wb_vrd2,
   output logic [31:0]            wb_data,
   output logic [VLEN-1:0]        wb_vdata1,
   output logic [VLEN-1:0]        wb_vdata2,
   output logic                   wb_we_x,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   import c3_pkg::*;

   // Sized to hold DEPTH so a misbehaving core cannot wrap the counter.
   localparam int IMAX = (PIPE_CYCLES > DEPTH) ? PIPE_CYCLES : DEPTH;
   localparam int IW   = $clog2(IMAX + 1);

   c3_result_t     wr_res;
   c3_result_t     head;
   c3_mode_t       mode;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic           take;
   logic           ret;
   logic [IW-1:0]  inflight;
   logic [IW-1:0]  discard_cnt;
   logic [IW-1:0]  remaining;

   assign wr_res = '{rd: in_rd, vrd1: in_vrd1, vrd2: in_vrd2, data: in_data,
                     vdata1: in_vdata1, vdata2: in_vdata2};

   assign wb_valid  = !empty;
   assign wb_rd     = head.rd;
   assign wb_vrd1   = head.vrd1;
   assign wb_vrd2   = head.vrd2;
   assign wb_data   = head.data;
   assign wb_vdata1 = head.vdata1;
   assign wb_vdata2 = head.vdata2;
   assign wb_we_x   = wb_valid && (head.rd != 5'd0);

   assign pop  = wb_valid && wb_ready && !flush;
   assign push = in_v && (mode == NORMAL) && !flush && (!full || pop);
   assign take = issue_v && issue_ok;
   assign ret  = in_v && (inflight != '0);

   // Results still owed by the pipeline once this cycle's arrival is accounted for.
   assign remaining = ret ? (inflight - IW'(1)) : inflight;

   assign issue_ok = (mode == NORMAL) &&
                     ((32'(count) + 32'(inflight)) < 32'(DEPTH));

   c3_wb_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(c3_result_t))
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .clear   (flush),
      .wdata   (wr_res),
      .rdata   (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= '0;
      end else begin
         case ({take, ret})
            2'b10:   inflight <= inflight + IW'(1);
            2'b01:   inflight <= inflight - IW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode        <= NORMAL;
         discard_cnt <= '0;
      end else if (flush) begin
         discard_cnt <= remaining;
         mode        <= (remaining != '0) ? DISCARD : NORMAL;
      end else if ((mode == DISCARD) && in_v) begin
         if (discard_cnt <= IW'(1)) begin
            discard_cnt <= '0;
            mode        <= NORMAL;
         end else begin
            discard_cnt <= discard_cnt - IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (in_v && (mode == NORMAL) && !flush && full && !pop) begin
         overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_c3_writeback_buffer.sv
// Directed bench for c3_writeback_buffer; a small delay-line stands in for the
// C3 pipeline so issued instructions return results PIPE cycles later.
module tb_c3_writeback_buffer;

   localparam int VLEN  = 128;
   localparam int DEPTH = 8;
   localparam int PIPE  = 5;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             issue_v;
   logic             issue_ok;
   logic             flush;
   logic             in_v;
   logic [4:0]       in_rd;
   logic [2:0]       in_vrd1;
   logic [2:0]       in_vrd2;
   logic [31:0]      in_data;
   logic [VLEN-1:0]  in_vdata1;
   logic [VLEN-1:0]  in_vdata2;
   logic             wb_valid;
   logic             wb_ready;
   logic [4:0]       wb_rd;
   logic [2:0]       wb_vrd1;
   logic [2:0]       wb_vrd2;
   logic [31:0]      wb_data;
   logic [VLEN-1:0]  wb_vdata1;
   logic [VLEN-1:0]  wb_vdata2;
   logic             wb_we_x;
   logic [3:0]       count;
   logic             overflow;

   int checks = 0;
   int errors = 0;
   int seq    = 0;
   int taken  = 0;
   int pipe [PIPE];
   bit auto_pipe = 1'b1;

   c3_writeback_buffer #(.DEPTH(DEPTH), .PIPE_CYCLES(PIPE), .VLEN(VLEN)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .issue_v   (issue_v),
      .issue_ok  (issue_ok),
      .flush     (flush),
      .in_v      (in_v),
      .in_rd     (in_rd),
      .in_vrd1   (in_vrd1),
      .in_vrd2   (in_vrd2),
      .in_data   (in_data),
      .in_vdata1 (in_vdata1),
      .in_vdata2 (in_vdata2),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_rd     (wb_rd),
      .wb_vrd1   (wb_vrd1),
      .wb_vrd2   (wb_vrd2),
      .wb_data   (wb_data),
      .wb_vdata1 (wb_vdata1),
      .wb_vdata2 (wb_vdata2),
      .wb_we_x   (wb_we_x),
      .count     (count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] rd_of(input int s);
      return 5'(s + 2);
   endfunction

   function automatic logic [31:0] data_of(input int s);
      return 32'h29 + 32'(s);
   endfunction

   task automatic drive_result(input int s);
      in_v      = (s != 0);
      in_rd     = (s != 0) ? rd_of(s) : 5'd0;
      in_vrd1   = 3'(s);
      in_vrd2   = ~3'(s);
      in_data   = (s != 0) ? data_of(s) : 32'd0;
      in_vdata1 = {4{in_data}};
      in_vdata2 = ~{4{in_data}};
   endtask

   task automatic drive_manual(input logic v, input logic [4:0] rd, input logic [31:0] d);
      in_v      = v;
      in_rd     = rd;
      in_vrd1   = 3'd0;
      in_vrd2   = 3'd0;
      in_data   = d;
      in_vdata1 = {4{d}};
      in_vdata2 = '0;
   endtask

   // One clock: note whether an issue is accepted, step the pipeline model, and
   // present its output for the next edge.
   task automatic tick();
      logic tk;
      tk = issue_v && issue_ok;
      @(posedge clk);
      #1;
      for (int i = PIPE - 1; i > 0; i--) pipe[i] = pipe[i-1];
      if (tk) begin
         seq++;
         taken++;
         pipe[0] = seq;
      end else begin
         pipe[0] = 0;
      end
      if (auto_pipe) drive_result(pipe[PIPE-1]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < PIPE; i++) pipe[i] = 0;
      reset_n  = 1'b0;
      issue_v  = 1'b0;
      flush    = 1'b0;
      wb_ready = 1'b0;
      drive_result(0);
      #3;
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_count",    count,    4'd0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_wb_data",  wb_data,  32'd0);
      check("rst_wb_we_x",  wb_we_x,  1'b0);
      check("rst_issue_ok", issue_ok, 1'b1);
      #10 reset_n = 1'b1;

      // Single result
      seq = 0;
      wb_ready = 1'b1;
      issue_v  = 1'b1;
      tick();
      issue_v = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("single_pre_valid", wb_valid, 1'b0);
      check("single_in_v", in_v, 1'b1);
      tick();
      check("single_valid",  wb_valid,  1'b1);
      check("single_rd",     wb_rd,     5'd3);
      check("single_data",   wb_data,   32'h2A);
      check("single_we_x",   wb_we_x,   1'b1);
      check("single_vdata1", wb_vdata1, {4{32'h2A}});
      tick();
      check("single_valid_gone", wb_valid, 1'b0);
      check("single_count",      count,    4'd0);
      check("single_inflight",   dut.inflight, 4'd0);

      // Credit limit
      seq = 0;
      taken = 0;
      wb_ready = 1'b0;
      issue_v  = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check("credit_ok_7", issue_ok, 1'b1);
      tick();
      check("credit_low_8", issue_ok, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      issue_v = 1'b0;
      check("credit_taken",    taken,    8);
      check("credit_count",    count,    4'd8);
      check("credit_overflow", overflow, 1'b0);
      check("credit_issue_ok", issue_ok, 1'b0);
      check("credit_inflight", dut.inflight, 4'd0);

      // Forced overflow
      auto_pipe = 1'b0;
      drive_manual(1'b1, 5'd7, 32'hDEAD);
      tick();
      drive_manual(1'b0, 5'd0, 32'd0);
      check("ovf_flag",  overflow, 1'b1);
      check("ovf_count", count,    4'd8);
      check("ovf_head",  wb_data,  data_of(1));
      tick();
      check("ovf_sticky", overflow, 1'b1);

      // Full with concurrent pop
      wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_manual(1'b1, 5'(i), 32'h100 + 32'(i));
         check("fullpop_head_data", wb_data, data_of(i + 1));
         check("fullpop_head_rd",   wb_rd,   rd_of(i + 1));
         tick();
         check("fullpop_count", count, 4'd8);
      end
      drive_manual(1'b0, 5'd0, 32'd0);
      for (int s = 5; s <= 8; s++) begin
         check("drain_old", wb_data, data_of(s));
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         check("drain_new",  wb_data, 32'h100 + 32'(i));
         check("drain_we_x", wb_we_x, (i != 0));
         tick();
      end
      check("drain_valid",    wb_valid, 1'b0);
      check("drain_count",    count,    4'd0);
      check("drain_overflow", overflow, 1'b1);

      // Flush with results in flight: issue at edges 1,2,5,6,7
      auto_pipe = 1'b1;
      seq = 0;
      wb_ready = 1'b0;
      issue_v = 1'b1;
      tick(); tick();
      issue_v = 1'b0;
      tick(); tick();
      issue_v = 1'b1;
      tick(); tick(); tick();
      issue_v = 1'b0;
      check("flush_pre_count",    count,        4'd2);
      check("flush_pre_inflight", dut.inflight, 4'd3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_count",    count,    4'd0);
      check("flush_valid",    wb_valid, 1'b0);
      check("flush_issue_ok", issue_ok, 1'b0);
      tick();
      check("flush_ok_e9", issue_ok, 1'b0);
      tick();
      check("flush_inflight_e10", dut.inflight, 4'd2);
      check("flush_count_e10",    count,        4'd0);
      tick();
      check("flush_ok_e11", issue_ok, 1'b0);
      tick();
      check("flush_ok_e12",    issue_ok,     1'b1);
      check("flush_count_e12", count,        4'd0);
      check("flush_inflight0", dut.inflight, 4'd0);

      // Async reset mid-cycle
      auto_pipe = 1'b0;
      drive_manual(1'b1, 5'd9, 32'h55);
      tick();
      drive_manual(1'b0, 5'd0, 32'd0);
      check("arst_pre_valid", wb_valid, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_valid",    wb_valid, 1'b0);
      check("arst_count",    count,    4'd0);
      check("arst_overflow", overflow, 1'b0);
      check("arst_data",     wb_data,  32'd0);
      for (int i = 0; i < PIPE; i++) pipe[i] = 0;
      #2 reset_n = 1'b1;
      #1;
      check("arst_issue_ok", issue_ok, 1'b1);
      check("arst_count_rel", count,   4'd0);
      tick();
      check("arst_valid_after", wb_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
